prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 192 +++++++++++++++++++
 tb/tb_prog_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: turns a byte stream into GrainFlex scan-chain programming
// signals (prog_clk/prog_rst/prog_en/prog_din). It can also re-stream the same
// bitstream in verify mode and flag any bit where the chain output differs.
module prog_loader #(
  parameter int CHAIN_LEN  = 1024,
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       verify,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       prog_clk,
  output logic       prog_rst,
  output logic       prog_en,
  output logic       prog_din,
  input  logic       prog_dout,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // Counter widths. The bit counter must be able to hold CHAIN_LEN itself.
  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RCW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CRST     = 3'd1;
  localparam logic [2:0] S_FETCH    = 3'd2;
  localparam logic [2:0] S_SHIFT_LO = 3'd3;
  localparam logic [2:0] S_SHIFT_HI = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [RCW-1:0]   rst_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic             vfy_mode;
  logic [7:0]       sreg;

  logic hs;
  logic phase_end;
  logic lo_end;
  logic hi_end;
  logic last_bit;
  logic nxt_shift;
  logic nxt_active;

  // The byte port is open only while waiting for a byte.
  assign s_ready   = (state == S_FETCH);
  assign hs        = s_ready & s_valid;
  assign phase_end = (div_cnt == DIV_LAST);
  assign lo_end    = (state == S_SHIFT_LO) & phase_end;
  assign hi_end    = (state == S_SHIFT_HI) & phase_end;
  assign last_bit  = (bit_cnt == BIT_LAST);

  // Outputs are registered from the next state so pin timing matches the
  // state the FSM is in during that cycle.
  assign nxt_shift  = (state_nxt == S_SHIFT_LO) | (state_nxt == S_SHIFT_HI);
  assign nxt_active = (state_nxt == S_FETCH) | nxt_shift;

  // Next-state selection for the programming sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = verify ? S_FETCH : S_CRST;
        end
      end
      S_CRST: begin
        if (rst_cnt == RST_LAST) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (s_valid) begin
          state_nxt = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (phase_end) begin
          state_nxt = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        // The final byte may be partial: stop on the chain length, never on
        // the byte boundary, so no extra byte is requested.
        if (phase_end) begin
          if (last_bit) begin
            state_nxt = S_FINISH;
          end else if (bit_idx == 3'd0) begin
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_SHIFT_LO;
          end
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state, counters, registered pins and the verify flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      rst_cnt  <= '0;
      bit_cnt  <= '0;
      bit_idx  <= 3'd0;
      vfy_mode <= 1'b0;
      prog_clk <= 1'b0;
      prog_rst <= 1'b0;
      prog_en  <= 1'b0;
      prog_din <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      prog_clk <= (state_nxt == S_SHIFT_HI);
      prog_rst <= (state_nxt == S_CRST);
      prog_en  <= nxt_active;
      busy     <= nxt_active | (state_nxt == S_CRST);
      done     <= (state_nxt == S_FINISH);

      // Chain-reset hold counter runs only while staying in CRST.
      if ((state == S_CRST) && (state_nxt == S_CRST)) begin
        rst_cnt <= rst_cnt + 1'b1;
      end else begin
        rst_cnt <= '0;
      end

      // Half-period divider restarts at every phase boundary.
      if (((state == S_SHIFT_LO) || (state == S_SHIFT_HI)) && !phase_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
      end

      if ((state == S_IDLE) && start) begin
        vfy_mode <= verify;
        error    <= 1'b0;
        bit_cnt  <= '0;
      end

      if (hs) begin
        bit_idx  <= 3'd7;
        prog_din <= s_data[7];
      end

      // Sample the chain output at the end of the low phase, before the
      // rising prog_clk shifts the chain.
      if (lo_end && vfy_mode && (prog_dout != prog_din)) begin
        error <= 1'b1;
      end

      if (hi_end) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (state_nxt == S_SHIFT_LO) begin
          bit_idx  <= bit_idx - 1'b1;
          prog_din <= sreg[6];
        end
      end
    end
  end

  // Byte shift register; bit 7 is always the bit currently on prog_din.
  always_ff @(posedge clk) begin
    if (hs) begin
      sreg <= s_data;
    end else if (hi_end && (state_nxt == S_SHIFT_LO)) begin
      sreg <= {sreg[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized passes on a 16-bit and a 12-bit
// chain, with a behavioural scan-chain model feeding prog_dout.
module tb_prog_loader;
  localparam int CLK_DIV    = 2;
  localparam int RST_CYCLES = 4;

  logic       clk;
  logic [1:0] rst_n_v, start_v, verify_v, s_valid_v, prog_dout_v;
  logic [7:0] s_data_v [2];
  wire  [1:0] s_ready_v, prog_clk_v, prog_rst_v, prog_en_v, prog_din_v;
  wire  [1:0] busy_v, done_v, error_v;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0] bytes [8];
  logic       ch [2][16];
  logic       last_load [2][16];
  int         clen [2];

  prog_loader #(.CHAIN_LEN(16), .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES)) dut16 (
    .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .verify(verify_v[0]),
    .s_data(s_data_v[0]), .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]),
    .prog_clk(prog_clk_v[0]), .prog_rst(prog_rst_v[0]), .prog_en(prog_en_v[0]),
    .prog_din(prog_din_v[0]), .prog_dout(prog_dout_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0])
  );

  prog_loader #(.CHAIN_LEN(12), .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES)) dut12 (
    .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .verify(verify_v[1]),
    .s_data(s_data_v[1]), .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]),
    .prog_clk(prog_clk_v[1]), .prog_rst(prog_rst_v[1]), .prog_en(prog_en_v[1]),
    .prog_din(prog_din_v[1]), .prog_dout(prog_dout_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int outs(input int sel);
    return int'({s_ready_v[sel], prog_clk_v[sel], prog_rst_v[sel], prog_en_v[sel],
                 prog_din_v[sel], busy_v[sel], done_v[sel], error_v[sel]});
  endfunction

  // One pass: start at cycle 0, feed bytes[] with optional backpressure,
  // model the chain, and compare against what the pass must look like.
  task automatic run_pass(input string name, input int sel, input bit vmode,
                          input int stall_at, input int stall_len, input bit abort,
                          input bit start_at_done, input int post);
    int L, nbytes, byte_i, stall_rem, c, nrise, n_rst, first_rst, first_rdy, n_hs;
    int err_first, ctl_bad, stall_bad, done_cyc, mis_k, exp_done, exp_err_cyc, post_bad;
    bit stalled, finished, aborted, prev_clk, err_at_done, stall_now;
    int rise_cyc [16];
    logic [15:0] got_v, exp_v;
    L = clen[sel];
    nbytes = (L + 7) / 8;
    byte_i = 0; stall_rem = 0; nrise = 0; n_rst = 0; first_rst = -1; first_rdy = -1;
    n_hs = 0; err_first = -1; ctl_bad = 0; stall_bad = 0; done_cyc = -1; mis_k = -1;
    post_bad = 0; stalled = 0; finished = 0; aborted = 0; prev_clk = 0; err_at_done = 0;
    got_v = '0; exp_v = '0;
    for (int k = 0; k < 16; k++) rise_cyc[k] = -1;
    for (int k = 0; k < L; k++) begin
      exp_v[k] = bytes[k / 8][7 - (k % 8)];
      if (vmode && mis_k < 0 && exp_v[k] !== last_load[sel][k]) mis_k = k;
    end
    c = 0;
    while (!finished && c < 3000) begin
      @(negedge clk);
      start_v[sel]  = (c == 0);
      verify_v[sel] = vmode;
      if (c > 0) begin
        if (prog_rst_v[sel]) begin
          n_rst++;
          if (first_rst < 0) first_rst = c;
          for (int p = 0; p < L; p++) ch[sel][p] = 1'b0;
          if (prog_en_v[sel]) ctl_bad++;
        end
        if (error_v[sel] && err_first < 0) err_first = c;
        if (prog_clk_v[sel] && !prev_clk) begin
          if (nrise < 16) begin
            got_v[nrise]    = prog_din_v[sel];
            rise_cyc[nrise] = c;
          end
          nrise++;
          if (prog_en_v[sel]) begin
            for (int p = 0; p < L - 1; p++) ch[sel][p] = ch[sel][p + 1];
            ch[sel][L - 1] = prog_din_v[sel];
          end
        end
        prog_dout_v[sel] = ch[sel][0];
        prev_clk = prog_clk_v[sel];
        if (done_v[sel]) begin
          finished    = 1;
          done_cyc    = c;
          err_at_done = error_v[sel];
          if (busy_v[sel] !== 1'b0) ctl_bad++;
          start_v[sel]  = start_at_done;
          verify_v[sel] = 1'b0;
        end else if (busy_v[sel] !== 1'b1) begin
          ctl_bad++;
        end
        if (abort && nrise == 4 && prog_en_v[sel] && !prog_clk_v[sel]) begin
          rst_n_v[sel] = 1'b0;
          #1;
          chk({name, ".outs_in_reset"}, outs(sel), 0);
          finished = 1;
          aborted  = 1;
        end
      end
      stall_now = 0;
      if (aborted) begin
        s_valid_v[sel] = 1'b0;
        start_v[sel]   = 1'b0;
      end else if (stall_rem > 0) begin
        stall_rem--;
        stall_now = 1;
      end else if (!stalled && stall_len > 0 && c > 0 && s_ready_v[sel] && byte_i == stall_at) begin
        stalled   = 1;
        stall_rem = stall_len - 1;
        stall_now = 1;
      end
      if (!aborted) s_valid_v[sel] = !stall_now;
      if (stall_now && (prog_clk_v[sel] !== 1'b0 || prog_en_v[sel] !== 1'b1 || s_ready_v[sel] !== 1'b1))
        stall_bad++;
      s_data_v[sel] = bytes[(byte_i < 8) ? byte_i : 7];
      if (c > 0 && s_ready_v[sel] && first_rdy < 0) first_rdy = c;
      if (c > 0 && s_valid_v[sel] && s_ready_v[sel]) begin
        n_hs++;
        byte_i++;
      end
      c++;
    end
    chk({name, ".finished"}, int'(finished), 1);
    if (finished && !aborted) begin
      exp_done = 1 + (vmode ? 0 : RST_CYCLES) + nbytes + 2 * CLK_DIV * L
                 + ((stall_len > 0 && stall_at < nbytes) ? stall_len : 0);
      exp_err_cyc = (mis_k < 0) ? -1 : rise_cyc[mis_k];
      chk({name, ".rises"},      nrise, L);
      chk({name, ".bits"},       int'(got_v), int'(exp_v));
      chk({name, ".bytes"},      n_hs, nbytes);
      chk({name, ".rst_cycles"}, n_rst, vmode ? 0 : RST_CYCLES);
      chk({name, ".rst_first"},  first_rst, vmode ? -1 : 1);
      chk({name, ".first_rdy"},  first_rdy, vmode ? 1 : RST_CYCLES + 1);
      chk({name, ".first_rise"}, rise_cyc[0], first_rdy + 1 + CLK_DIV);
      chk({name, ".done_cyc"},   done_cyc, exp_done);
      chk({name, ".err_cyc"},    err_first, exp_err_cyc);
      chk({name, ".err_done"},   int'(err_at_done), int'(mis_k >= 0));
      chk({name, ".ctl"},        ctl_bad, 0);
      if (stall_len > 0) chk({name, ".stall_idle"}, stall_bad, 0);
      if (!vmode) for (int k = 0; k < L; k++) last_load[sel][k] = exp_v[k];
      for (int p = 0; p < post; p++) begin
        @(negedge clk);
        start_v[sel] = 1'b0;
        if (done_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0 || s_ready_v[sel] !== 1'b0 ||
            prog_en_v[sel] !== 1'b0 || prog_clk_v[sel] !== 1'b0 ||
            error_v[sel] !== (mis_k >= 0))
          post_bad++;
      end
      if (post > 0) chk({name, ".post_idle"}, post_bad, 0);
    end
  endtask

  initial begin
    int sel, sl, j, b;
    clen[0] = 16;
    clen[1] = 12;
    rst_n_v = 2'b00; start_v = 2'b00; verify_v = 2'b00; s_valid_v = 2'b00;
    prog_dout_v = 2'b00;
    s_data_v[0] = 8'h00; s_data_v[1] = 8'h00;
    for (int k = 0; k < 16; k++) begin
      ch[0][k] = 0; ch[1][k] = 0; last_load[0][k] = 0; last_load[1][k] = 0;
    end
    for (int k = 0; k < 8; k++) bytes[k] = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_outs16", outs(0), 0);
    chk("reset_outs12", outs(1), 0);
    rst_n_v = 2'b11;
    @(negedge clk);
    chk("idle_outs16", outs(0), 0);
    chk("idle_outs12", outs(1), 0);

    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h55;
    run_pass("basic_load",   0, 0, 0, 0, 0, 0, 3);
    run_pass("clean_verify", 0, 1, 0, 0, 0, 0, 2);
    bytes[1] = 8'h3D;
    run_pass("bad_verify",   0, 1, 0, 0, 0, 1, 2);
    bytes[1] = 8'h3C;
    run_pass("reload",       0, 0, 0, 0, 0, 1, 0);
    run_pass("b2b_verify",   0, 1, 0, 0, 0, 0, 1);

    bytes[0] = 8'hFF; bytes[1] = 8'hA0; bytes[2] = 8'h55;
    run_pass("partial_load",   1, 0, 0, 0, 0, 0, 3);
    run_pass("partial_verify", 1, 1, 0, 0, 0, 0, 2);

    bytes[0] = 8'hA5; bytes[1] = 8'h3C;
    run_pass("stall_load",   0, 0, 1, 10, 0, 0, 2);
    run_pass("stall_verify", 0, 1, 1, 10, 0, 0, 2);

    run_pass("abort", 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n_v[0] = 1'b1;
    @(negedge clk);
    chk("abort_idle", outs(0), 0);
    run_pass("after_abort_load",   0, 0, 0, 0, 0, 0, 1);
    run_pass("after_abort_verify", 0, 1, 0, 0, 0, 0, 1);

    for (int it = 0; it < 6; it++) begin
      sel = int'($urandom_range(1, 0));
      for (int k = 0; k < 8; k++) bytes[k] = 8'($urandom);
      sl = int'($urandom_range(12, 0));
      run_pass($sformatf("rnd%0d_load", it), sel, 0, 1, sl, 0, 0, 1);
      if ($urandom_range(1, 0) == 1) begin
        j = int'($urandom_range(1, 0));
        b = int'($urandom_range(7, 0));
        bytes[j] = bytes[j] ^ (8'h01 << b);
      end
      sl = int'($urandom_range(12, 0));
      run_pass($sformatf("rnd%0d_verify", it), sel, 1, 1, sl, 0, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
